// File: rtl/synth_pkg.sv
// Shared constants for the envelope and mixer stages.
// Holds the mixer FSM encoding and the fixed-point shift amounts.
package synth_pkg;

    localparam logic [1:0] MIX_IDLE  = 2'd0;
    localparam logic [1:0] MIX_MAC   = 2'd1;
    localparam logic [1:0] MIX_SCALE = 2'd2;

    localparam int VOL_FRAC_SHIFT = 17;
    localparam int GAIN_SHIFT     = 6;

    localparam logic [17:0] VOLUME_MAX = 18'h1FFFF;

endpackage

// File: rtl/voice_mixer_sat.sv
// Signed clamp from IN_W bits down to OUT_W bits.
// Reports whether the value had to be clamped.
module voice_mixer_sat #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    localparam logic signed [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

    logic [IN_W-OUT_W:0] top;

    // In range iff every bit above the output sign bit matches it.
    always_comb begin
        top  = din[IN_W-1:OUT_W-1];
        clip = !((&top) || (~|top));
        dout = din[OUT_W-1:0];
        if (clip) begin
            dout = din[IN_W-1] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Multi-voice mixer: shared MAC over snapshotted voices, master gain, saturation.
// VOICE_MIXER_CLIP_COUNT_EN adds a saturating count of clipped frames.
module voice_mixer
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       new_sample,
    input  logic [NUM_VOICES*16-1:0]   voice_sample,
    input  logic [NUM_VOICES*18-1:0]   voice_volume,
    input  logic [NUM_VOICES-1:0]      voice_active,
    input  logic [6:0]                 master_gain,
    output logic signed [OUT_W-1:0]    mix_out,
    output logic                       mix_valid,
    output logic                       busy,
    output logic                       clip,
    output logic                       overrun,
    output logic [15:0]                clip_count
);

    localparam int AW = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PW = SAMPLE_W + 18;
    localparam int GW = AW + 8;

    logic [1:0]                 state;
    logic [IW-1:0]              idx;
    logic signed [SAMPLE_W-1:0] samp_q [NUM_VOICES];
    logic [17:0]                vol_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0]      act_q;
    logic [6:0]                 gain_q;
    logic signed [AW-1:0]       acc;

    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    term_full;
    logic signed [AW-1:0]    term;
    logic signed [GW-1:0]    gprod;
    logic signed [GW-1:0]    gval;
    logic signed [OUT_W-1:0] sat_out;
    logic                    sat_clip;

    // vol_q[17] is always 0, so the signed view is the plain magnitude.
    always_comb begin
        prod      = samp_q[idx] * $signed(vol_q[idx]);
        term_full = prod >>> VOL_FRAC_SHIFT;
        term      = act_q[idx] ? term_full[AW-1:0] : '0;
        gprod     = acc * $signed({1'b0, gain_q});
        gval      = gprod >>> GAIN_SHIFT;
    end

    voice_mixer_sat #(
        .IN_W  (GW),
        .OUT_W (OUT_W)
    ) u_sat (
        .din  (gval),
        .dout (sat_out),
        .clip (sat_clip)
    );

    assign busy = (state != MIX_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= MIX_IDLE;
            idx       <= '0;
            act_q     <= '0;
            gain_q    <= '0;
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                samp_q[i] <= '0;
                vol_q[i]  <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            case (state)
                MIX_IDLE: begin
                    if (new_sample) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            samp_q[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
                            vol_q[i]  <= voice_volume[i*18 +: 18] & VOLUME_MAX;
                        end
                        act_q  <= voice_active;
                        gain_q <= master_gain;
                        acc    <= '0;
                        idx    <= '0;
                        state  <= MIX_MAC;
                    end
                end
                MIX_MAC: begin
                    acc <= acc + term;
                    if (idx == IW'(NUM_VOICES - 1)) begin
                        state <= MIX_SCALE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                    if (new_sample) overrun <= 1'b1;
                end
                MIX_SCALE: begin
                    mix_out   <= sat_out;
                    clip      <= sat_clip;
                    mix_valid <= 1'b1;
                    state     <= MIX_IDLE;
                    if (new_sample) overrun <= 1'b1;
                end
                default: state <= MIX_IDLE;
            endcase
        end
    end

`ifdef VOICE_MIXER_CLIP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_count <= '0;
        end else if (state == MIX_SCALE && sat_clip && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`else
    assign clip_count = '0;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed frames plus random frames
// checked against an arithmetic reference model.
module tb_voice_mixer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               new_sample;
    logic [63:0]        voice_sample;
    logic [71:0]        voice_volume;
    logic [3:0]         voice_active;
    logic [6:0]         master_gain;
    logic signed [15:0] mix_out;
    logic               mix_valid;
    logic               busy;
    logic               clip;
    logic               overrun;
    logic [15:0]        clip_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cc = 0;

    voice_mixer #(
        .NUM_VOICES (4),
        .SAMPLE_W   (16),
        .OUT_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_sample   (new_sample),
        .voice_sample (voice_sample),
        .voice_volume (voice_volume),
        .voice_active (voice_active),
        .master_gain  (master_gain),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .clip         (clip),
        .overrun      (overrun),
        .clip_count   (clip_count)
    );

    always #5 clk = ~clk;

    function automatic void model(
        input  logic [63:0] smp,
        input  logic [71:0] vol,
        input  logic [3:0]  act,
        input  logic [6:0]  gain,
        output logic signed [15:0] eo,
        output logic ec
    );
        longint sum;
        longint s;
        longint v;
        longint g;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            s = longint'($signed(smp[i*16 +: 16]));
            v = longint'(vol[i*18 +: 17]);
            if (act[i]) sum += (s * v) >>> 17;
        end
        g = (sum * longint'(gain)) >>> 6;
        ec = (g > 32767) || (g < -32768);
        if (g > 32767) g = 32767;
        if (g < -32768) g = -32768;
        eo = 16'(g);
    endfunction

    function automatic void note_clip(input logic ec);
`ifdef VOICE_MIXER_CLIP_COUNT_EN
        if (ec && exp_cc < 65535) exp_cc++;
`else
        if (ec) exp_cc = 0;
`endif
    endfunction

    // Caller is at a negedge with the DUT idle (or in its mix_valid cycle).
    task automatic run_frame(
        input  logic [63:0] smp,
        input  logic [71:0] vol,
        input  logic [3:0]  act,
        input  logic [6:0]  gain,
        output int lat
    );
        logic bad_busy;
        voice_sample = smp;
        voice_volume = vol;
        voice_active = act;
        master_gain  = gain;
        new_sample   = 1'b1;
        lat          = -1;
        bad_busy     = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            new_sample   = 1'b0;
            voice_sample = {$urandom, $urandom};
            voice_volume = {8'($urandom), $urandom, $urandom};
            voice_active = 4'($urandom);
            master_gain  = 7'($urandom);
            if (mix_valid) begin
                lat = k;
                if (busy) bad_busy = 1'b1;
                break;
            end
            if (!busy) bad_busy = 1'b1;
        end
        n_cmp++;
        if (lat != 6) begin
            n_bad++;
            $display("FAIL latency: got %0d required 6", lat);
        end
        n_cmp++;
        if (bad_busy) begin
            n_bad++;
            $display("FAIL busy_window: busy not high exactly over T+1..T+5");
        end
    endtask

    task automatic check_frame(
        input string nm,
        input logic signed [15:0] eo,
        input logic ec
    );
        n_cmp++;
        if (mix_out !== eo) begin
            n_bad++;
            $display("FAIL %s mix_out: got %0d required %0d", nm, mix_out, eo);
        end
        n_cmp++;
        if (clip !== ec) begin
            n_bad++;
            $display("FAIL %s clip: got %0b required %0b", nm, clip, ec);
        end
        note_clip(ec);
        n_cmp++;
        if (clip_count !== 16'(exp_cc)) begin
            n_bad++;
            $display("FAIL %s clip_count: got %0d required %0d", nm, clip_count, exp_cc);
        end
    endtask

    task automatic check_zero(input string nm);
        n_cmp++;
        if ({mix_out, mix_valid, busy, clip, overrun, clip_count} !== 35'd0) begin
            n_bad++;
            $display("FAIL %s zero: got out=%0d v=%0b b=%0b c=%0b o=%0b cc=%0d required all 0",
                     nm, mix_out, mix_valid, busy, clip, overrun, clip_count);
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        new_sample   = 1'b0;
        voice_sample = '0;
        voice_volume = '0;
        voice_active = '0;
        master_gain  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n  = 1'b1;
        exp_cc = 0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        int lat;
        run_frame({48'd0, 16'h4000}, {54'd0, 18'h1FFFF}, 4'b0001, 7'd64, lat);
        check_frame("single_voice", 16'sd16383, 1'b0);
        run_frame({4{16'h4000}}, {4{18'h1FFFF}}, 4'hF, 7'd64, lat);
        check_frame("pos_clip", 16'sh7FFF, 1'b1);
        run_frame({4{16'h8000}}, {4{18'h1FFFF}}, 4'hF, 7'd64, lat);
        check_frame("neg_clip", -16'sd32768, 1'b1);
        run_frame({48'd0, 16'd1000}, {54'd0, 18'h10000}, 4'b0001, 7'd32, lat);
        check_frame("half_gain", 16'sd250, 1'b0);
        run_frame({48'd0, 16'd1000}, {54'd0, 18'h10000}, 4'b0000, 7'd32, lat);
        check_frame("inactive", 16'sd0, 1'b0);
        // bit 17 of the volume must be ignored
        run_frame({48'd0, 16'd1000}, {54'd0, 18'h30000}, 4'b0001, 7'd64, lat);
        check_frame("vol_bit17", 16'sd500, 1'b0);
    endtask

    task automatic test_random;
        logic [63:0] s;
        logic [71:0] v;
        logic [3:0] a;
        logic [6:0] g;
        logic signed [15:0] eo;
        logic ec;
        int lat;
        for (int n = 0; n < 40; n++) begin
            s = {$urandom, $urandom};
            v = {8'($urandom), $urandom, $urandom};
            a = 4'($urandom);
            g = (n % 4 == 0) ? 7'd127 : 7'($urandom);
            model(s, v, a, g, eo, ec);
            run_frame(s, v, a, g, lat);
            check_frame("random", eo, ec);
        end
    endtask

    task automatic test_overrun;
        logic [63:0] s;
        logic signed [15:0] eo;
        logic ec;
        int nv;
        s = {16'd300, 16'd200, 16'd100, 16'd50};
        model(s, {4{18'h1FFFF}}, 4'hF, 7'd64, eo, ec);
        voice_sample = s;
        voice_volume = {4{18'h1FFFF}};
        voice_active = 4'hF;
        master_gain  = 7'd64;
        new_sample   = 1'b1;
        nv = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            new_sample   = (k == 2);
            voice_sample = {4{16'h7FFF}};
            if (mix_valid) begin
                nv++;
                check_frame("overrun_frame", eo, ec);
            end
        end
        n_cmp++;
        if (nv != 1) begin
            n_bad++;
            $display("FAIL overrun_valid_count: got %0d required 1", nv);
        end
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_flag: got %0b required 1", overrun);
        end
    endtask

    task automatic test_back_to_back;
        logic signed [15:0] eo;
        logic ec;
        int lat;
        run_frame({48'd0, 16'd2000}, {54'd0, 18'h10000}, 4'b0001, 7'd64, lat);
        model({48'd0, 16'd2000}, {54'd0, 18'h10000}, 4'b0001, 7'd64, eo, ec);
        check_frame("b2b_first", eo, ec);
        // strobe lands in the mix_valid cycle of the previous frame
        run_frame({16'd0, 16'hF000, 32'd0}, {18'd0, 18'h1FFFF, 36'd0}, 4'b0100, 7'd100, lat);
        model({16'd0, 16'hF000, 32'd0}, {18'd0, 18'h1FFFF, 36'd0}, 4'b0100, 7'd100, eo, ec);
        check_frame("b2b_second", eo, ec);
    endtask

    task automatic test_reset_mid;
        int nv;
        voice_sample = {4{16'h4000}};
        voice_volume = {4{18'h1FFFF}};
        voice_active = 4'hF;
        master_gain  = 7'd64;
        new_sample   = 1'b1;
        repeat (3) @(negedge clk) new_sample = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        exp_cc = 0;
        check_zero("reset_mid");
        rst_n = 1'b1;
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (mix_valid) nv++;
        end
        n_cmp++;
        if (nv != 0) begin
            n_bad++;
            $display("FAIL reset_mid_valid: got %0d pulses required 0", nv);
        end
    endtask

    task automatic test_clip_count;
        int lat;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        exp_cc = 0;
        for (int n = 0; n < 3; n++) begin
            run_frame({4{16'h4000}}, {4{18'h1FFFF}}, 4'hF, 7'd64, lat);
            check_frame("clip_count", 16'sh7FFF, 1'b1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        exp_cc = 0;
        rst_n = 1'b1;
        check_zero("clip_count_reset");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_overrun;
        test_reset_mid;
        test_clip_count;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
